// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU port (c_*), debug/loader port (d_*), memory port (m_*)
// and arbiter status (busy, owner) bundled for the two-master memory arbiter.
// slave  = the arbiter's view; master = the view of the surrounding system.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // CPU port
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wd;
  logic [DATA_W-1:0] c_rd;
  logic              c_ack;
  // debug/loader port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wd;
  logic [DATA_W-1:0] d_rd;
  logic              d_ack;
  // memory port
  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wd;
  logic [DATA_W-1:0] m_rd;
  // status
  logic              busy;
  logic              owner;

  modport slave (
    input  c_req, c_we, c_addr, c_wd,
    input  d_req, d_we, d_addr, d_wd,
    input  m_rd,
    output c_rd, c_ack, d_rd, d_ack,
    output m_en, m_we, m_addr, m_wd,
    output busy, owner
  );

  modport master (
    output c_req, c_we, c_addr, c_wd,
    output d_req, d_we, d_addr, d_wd,
    output m_rd,
    input  c_rd, c_ack, d_rd, d_ack,
    input  m_en, m_we, m_addr, m_wd,
    input  busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the CPU (C) and a debug/loader
// master (D). One transaction at a time: IDLE -> ISSUE -> WAIT x MEM_LAT -> RESP.
// Build option: define DEBUG_PRIO_EN for fixed priority (D beats C on a tie);
// without it, ties are resolved round-robin against the last grant.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        lat_cnt;
  logic              last;       // last grant: 0=C, 1=D
  logic              any_req;
  logic              grant_d;    // arbitration result: 1 selects D
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wd;

  assign any_req = bus.c_req | bus.d_req;

`ifdef DEBUG_PRIO_EN
  // D wins whenever it requests; C can be starved by a persistent d_req.
  assign grant_d = bus.d_req;
`else
  // D wins if alone, or on a tie when C was served last.
  assign grant_d = bus.d_req & (~bus.c_req | ~last);
`endif

  assign sel_we   = grant_d ? bus.d_we   : bus.c_we;
  assign sel_addr = grant_d ? bus.d_addr : bus.c_addr;
  assign sel_wd   = grant_d ? bus.d_wd   : bus.c_wd;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values, whatever the block order.
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (any_req) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (lat_cnt == 4'd0) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state: strobe, acks and busy
  always_comb begin
    bus.m_en  = (state == S_ISSUE);
    bus.busy  = (state != S_IDLE);
    bus.c_ack = (state == S_RESP) & ~bus.owner;
    bus.d_ack = (state == S_RESP) &  bus.owner;
  end

  // Datapath: latch the winner, run the latency counter, capture read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.m_we   <= 1'b0;
      bus.m_addr <= '0;
      bus.m_wd   <= '0;
      bus.c_rd   <= '0;
      bus.d_rd   <= '0;
      bus.owner  <= 1'b1;
      last       <= 1'b1;      // C wins the first tie
      lat_cnt    <= 4'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (any_req) begin
            bus.m_we   <= sel_we;
            bus.m_addr <= sel_addr;
            bus.m_wd   <= sel_wd;
            bus.owner  <= grant_d;
            last       <= grant_d;
          end
        end
        S_ISSUE: begin
          lat_cnt <= 4'(MEM_LAT - 1);
        end
        S_WAIT: begin
          if (lat_cnt == 4'd0) begin
            // m_rd is valid this cycle; writes leave both rd registers alone
            if (!bus.m_we) begin
              if (bus.owner) bus.d_rd <= bus.m_rd;
              else           bus.c_rd <= bus.m_rd;
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // The 4-bit latency counter only covers 1..15 cycles
  a_mem_lat_range: assert property (@(posedge clk) disable iff (rst)
    (MEM_LAT >= 1 && MEM_LAT <= 15))
    else $error("mem_arbiter: MEM_LAT=%0d outside 1..15", MEM_LAT);

endmodule
